// File: rtl/udp_rx_strip_32.sv
// udp_rx_strip_32
//   Receives the 32-bit AXIS byte stream from the 8->32 width converter,
//   checks the Ethernet/IPv4/UDP header (42 bytes, no IP options), drops
//   frames not addressed to LOCAL_IP:UDP_PORT, strips the header, and
//   re-aligns the payload by 2 bytes into an MSB-aligned output stream.
//   Frame metadata (source IP/port, payload length) is presented with a
//   one-cycle meta_valid pulse.
//
// Ports
//   clk_32, reset_32_n             clock, async active-low reset
//   axis_*_in / axis_tready_out    input stream (partial last word right-aligned)
//   axis_*_out / axis_tready_in    output stream (partial last word MSB-aligned)
//   meta_valid, meta_src_ip, meta_src_port, meta_len   accepted-frame metadata
//   frame_ok_cnt, frame_drop_cnt   saturating frame counters
//
// Build option
//   UDP_RX_IP_CSUM_EN : when defined, frames whose IPv4 header checksum does
//   not verify are dropped.
module udp_rx_strip_32 #(
  parameter logic [15:0] UDP_PORT = 16'h1F90,
  parameter logic [31:0] LOCAL_IP = 32'hC0A80102,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_32,
  input  logic             reset_32_n,
  input  logic [31:0]      axis_tdata_in,
  input  logic [3:0]       axis_tkeep_in,
  input  logic             axis_tvalid_in,
  input  logic             axis_tlast_in,
  output logic             axis_tready_out,
  output logic [31:0]      axis_tdata_out,
  output logic [3:0]       axis_tkeep_out,
  output logic             axis_tvalid_out,
  output logic             axis_tlast_out,
  input  logic             axis_tready_in,
  output logic             meta_valid,
  output logic [31:0]      meta_src_ip,
  output logic [15:0]      meta_src_port,
  output logic [15:0]      meta_len,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_drop_cnt
);

  typedef enum logic [1:0] {HDR, PAYLOAD, FLUSH, DROP} state_t;

  state_t      state, state_nx;
  logic [3:0]  wcnt, wcnt_nx;
  logic [15:0] residue, residue_nx;
  logic [15:0] rem, rem_nx;
  logic [2:0]  flush_n, flush_n_nx;
  logic        pad_ok, pad_ok_nx;
  logic [31:0] src_ip_sh;
  logic [15:0] src_port_sh;

  logic [31:0] cur;
  logic [2:0]  n_in, avail;
  logic        out_free, hdr_fail, csum_bad, hdr_acc;
  logic        ld_out, ld_last, meta_ld, inc_ok, inc_drop;
  logic [31:0] ld_data;
  logic [2:0]  ld_cnt;
  logic [3:0]  ld_keep;

  function automatic logic [3:0] keep_of(input logic [2:0] k);
    case (k)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1100;
      3'd3:    return 4'b1110;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Left-justify a partial last word so byte 0 of the beat is always [31:24].
  always_comb begin
    n_in = 3'd4;
    cur  = axis_tdata_in;
    if (axis_tlast_in) begin
      case (axis_tkeep_in)
        4'b0001: begin n_in = 3'd1; cur = {axis_tdata_in[7:0], 24'd0};  end
        4'b0011: begin n_in = 3'd2; cur = {axis_tdata_in[15:0], 16'd0}; end
        4'b0111: begin n_in = 3'd3; cur = {axis_tdata_in[23:0], 8'd0};  end
        default: ;
      endcase
    end
  end

  assign hdr_acc  = (state == HDR) && axis_tvalid_in;
  assign out_free = ~axis_tvalid_out | axis_tready_in;
  assign avail    = 3'd2 + n_in;

`ifdef UDP_RX_IP_CSUM_EN
  logic [15:0] csum_acc, csum_nx;

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // IP header occupies w3[15:0] .. w8[31:16]; the total must be all-ones.
  always_comb begin
    csum_nx = csum_acc;
    case (wcnt)
      4'd3:                   csum_nx = cur[15:0];
      4'd4, 4'd5, 4'd6, 4'd7: csum_nx = oc_add(oc_add(csum_acc, cur[31:16]), cur[15:0]);
      4'd8:                   csum_nx = oc_add(csum_acc, cur[31:16]);
      default: ;
    endcase
  end
  assign csum_bad = (csum_nx != 16'hFFFF);

  always_ff @(posedge clk_32 or negedge reset_32_n) begin
    if (!reset_32_n)  csum_acc <= '0;
    else if (hdr_acc) csum_acc <= csum_nx;
  end
`else
  assign csum_bad = 1'b0;
`endif

  always_comb begin
    hdr_fail = 1'b0;
    case (wcnt)
      4'd3: hdr_fail = (cur[31:16] != 16'h0800) || (cur[15:8] != 8'h45);
      4'd5: hdr_fail = (cur[7:0] != 8'h11);
      4'd7: hdr_fail = (cur[15:0] != LOCAL_IP[31:16]);
      4'd8: hdr_fail = (cur[31:16] != LOCAL_IP[15:0]) || csum_bad;
      4'd9: hdr_fail = (cur[31:16] != UDP_PORT) || (cur[15:0] <= 16'd8);
      default: ;
    endcase
  end

  always_comb begin
    state_nx        = state;
    wcnt_nx         = wcnt;
    residue_nx      = residue;
    rem_nx          = rem;
    flush_n_nx      = flush_n;
    pad_ok_nx       = pad_ok;
    axis_tready_out = 1'b0;
    ld_out          = 1'b0;
    ld_data         = '0;
    ld_cnt          = 3'd0;
    ld_last         = 1'b0;
    meta_ld         = 1'b0;
    inc_ok          = 1'b0;
    inc_drop        = 1'b0;
    case (state)
      HDR: begin
        axis_tready_out = 1'b1;
        if (axis_tvalid_in) begin
          wcnt_nx = wcnt + 4'd1;
          if (axis_tlast_in) begin
            wcnt_nx  = '0;
            inc_drop = 1'b1;
          end else if (hdr_fail) begin
            wcnt_nx   = '0;
            pad_ok_nx = 1'b0;
            state_nx  = DROP;
          end else if (wcnt == 4'd9) begin
            meta_ld = 1'b1;
          end else if (wcnt == 4'd10) begin
            wcnt_nx    = '0;
            residue_nx = cur[15:0];
            rem_nx     = meta_len;
            state_nx   = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        axis_tready_out = out_free;
        if (axis_tvalid_in && out_free) begin
          // Two residue bytes lead; the upper half of this beat completes the word.
          ld_out     = 1'b1;
          ld_data    = {residue, cur[31:16]};
          residue_nx = cur[15:0];
          if (rem <= 16'd4 && rem <= 16'(avail)) begin
            // UDP length satisfied; anything after is Ethernet padding.
            ld_cnt  = rem[2:0];
            ld_last = 1'b1;
            rem_nx  = '0;
            if (axis_tlast_in) begin
              inc_ok   = 1'b1;
              state_nx = HDR;
            end else begin
              pad_ok_nx = 1'b1;
              state_nx  = DROP;
            end
          end else if (axis_tlast_in && avail <= 3'd4) begin
            ld_cnt   = avail;
            ld_last  = 1'b1;
            rem_nx   = '0;
            inc_ok   = 1'b1;
            state_nx = HDR;
          end else begin
            ld_cnt = 3'd4;
            rem_nx = rem - 16'd4;
            if (axis_tlast_in) begin
              flush_n_nx = avail - 3'd4;
              inc_ok     = 1'b1;
              state_nx   = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          ld_out   = 1'b1;
          ld_data  = {residue, 16'd0};
          ld_cnt   = (rem < 16'(flush_n)) ? rem[2:0] : flush_n;
          ld_last  = 1'b1;
          rem_nx   = '0;
          state_nx = HDR;
        end
      end
      DROP: begin
        axis_tready_out = 1'b1;
        if (axis_tvalid_in && axis_tlast_in) begin
          inc_ok    = pad_ok;
          inc_drop  = ~pad_ok;
          pad_ok_nx = 1'b0;
          state_nx  = HDR;
        end
      end
      default: state_nx = HDR;
    endcase
  end

  assign ld_keep = keep_of(ld_cnt);

  always_ff @(posedge clk_32 or negedge reset_32_n) begin
    if (!reset_32_n) begin
      state   <= HDR;
      wcnt    <= '0;
      residue <= '0;
      rem     <= '0;
      flush_n <= '0;
      pad_ok  <= 1'b0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      residue <= residue_nx;
      rem     <= rem_nx;
      flush_n <= flush_n_nx;
      pad_ok  <= pad_ok_nx;
    end
  end

  always_ff @(posedge clk_32 or negedge reset_32_n) begin
    if (!reset_32_n) begin
      axis_tvalid_out <= 1'b0;
      axis_tdata_out  <= '0;
      axis_tkeep_out  <= '0;
      axis_tlast_out  <= 1'b0;
    end else if (ld_out) begin
      axis_tvalid_out <= 1'b1;
      axis_tdata_out  <= ld_data & {{8{ld_keep[3]}}, {8{ld_keep[2]}}, {8{ld_keep[1]}}, {8{ld_keep[0]}}};
      axis_tkeep_out  <= ld_keep;
      axis_tlast_out  <= ld_last;
    end else if (axis_tready_in) begin
      axis_tvalid_out <= 1'b0;
    end
  end

  // Source fields go to shadows first so the metadata outputs only change on meta_valid.
  always_ff @(posedge clk_32 or negedge reset_32_n) begin
    if (!reset_32_n) begin
      src_ip_sh     <= '0;
      src_port_sh   <= '0;
      meta_valid    <= 1'b0;
      meta_src_ip   <= '0;
      meta_src_port <= '0;
      meta_len      <= '0;
    end else begin
      meta_valid <= meta_ld;
      if (hdr_acc) begin
        if (wcnt == 4'd6) src_ip_sh[31:16] <= cur[15:0];
        if (wcnt == 4'd7) src_ip_sh[15:0]  <= cur[31:16];
        if (wcnt == 4'd8) src_port_sh      <= cur[15:0];
      end
      if (meta_ld) begin
        meta_src_ip   <= src_ip_sh;
        meta_src_port <= src_port_sh;
        meta_len      <= cur[15:0] - 16'd8;
      end
    end
  end

  always_ff @(posedge clk_32 or negedge reset_32_n) begin
    if (!reset_32_n) begin
      frame_ok_cnt   <= '0;
      frame_drop_cnt <= '0;
    end else begin
      if (inc_ok && frame_ok_cnt != '1)     frame_ok_cnt   <= frame_ok_cnt + 1'b1;
      if (inc_drop && frame_drop_cnt != '1) frame_drop_cnt <= frame_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_rx_strip_32.sv
`timescale 1ns/1ps
module tb_udp_rx_strip_32;

  logic        clk_32 = 1'b0;
  logic        reset_32_n;
  logic [31:0] axis_tdata_in;
  logic [3:0]  axis_tkeep_in;
  logic        axis_tvalid_in;
  logic        axis_tlast_in;
  logic        axis_tready_out;
  logic [31:0] axis_tdata_out;
  logic [3:0]  axis_tkeep_out;
  logic        axis_tvalid_out;
  logic        axis_tlast_out;
  logic        axis_tready_in = 1'b1;
  logic        meta_valid;
  logic [31:0] meta_src_ip;
  logic [15:0] meta_src_port;
  logic [15:0] meta_len;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_drop_cnt;

  always #5 clk_32 = ~clk_32;

  udp_rx_strip_32 #(.UDP_PORT(16'h1F90), .LOCAL_IP(32'hC0A80102), .CNT_W(16)) dut (
    .clk_32(clk_32), .reset_32_n(reset_32_n),
    .axis_tdata_in(axis_tdata_in), .axis_tkeep_in(axis_tkeep_in),
    .axis_tvalid_in(axis_tvalid_in), .axis_tlast_in(axis_tlast_in),
    .axis_tready_out(axis_tready_out),
    .axis_tdata_out(axis_tdata_out), .axis_tkeep_out(axis_tkeep_out),
    .axis_tvalid_out(axis_tvalid_out), .axis_tlast_out(axis_tlast_out),
    .axis_tready_in(axis_tready_in),
    .meta_valid(meta_valid), .meta_src_ip(meta_src_ip),
    .meta_src_port(meta_src_port), .meta_len(meta_len),
    .frame_ok_cnt(frame_ok_cnt), .frame_drop_cnt(frame_drop_cnt)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Output monitor: records handshakes, meta pulses, tready_out-low cycles, stall holds.
  logic [31:0] ob_data[$];
  logic [3:0]  ob_keep[$];
  logic        ob_last[$];
  int unsigned meta_cnt = 0;
  int unsigned rdy_low  = 0;
  logic        prev_stall = 1'b0;
  logic [37:0] prev_word  = '0;
  logic        rand_rdy   = 1'b0;

  always @(negedge clk_32) begin
    if (prev_stall)
      chk("hold", {axis_tvalid_out, axis_tlast_out, axis_tkeep_out, axis_tdata_out}, prev_word);
    prev_stall = reset_32_n && axis_tvalid_out && !axis_tready_in;
    prev_word  = {axis_tvalid_out, axis_tlast_out, axis_tkeep_out, axis_tdata_out};
    if (axis_tvalid_out && axis_tready_in) begin
      ob_data.push_back(axis_tdata_out);
      ob_keep.push_back(axis_tkeep_out);
      ob_last.push_back(axis_tlast_out);
    end
    if (meta_valid) meta_cnt++;
    if (!axis_tready_out) rdy_low++;
  end

  always @(posedge clk_32) begin
    #1;
    axis_tready_in = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [7:0]  frm[$];
  int unsigned stalls = 0;
  int unsigned exp_ok = 0;
  int unsigned exp_drop = 0;

  task automatic build(input logic [15:0] etype, input logic [31:0] dip, input logic [15:0] dport,
                       input int unsigned plen, input int unsigned seed, input int unsigned padto);
    logic [31:0] sum;
    logic [15:0] ulen, tlen;
    ulen = 16'(8 + plen);
    tlen = 16'(28 + plen);
    frm.delete();
    for (int unsigned i = 0; i < 12; i++) frm.push_back(8'(8'h11 * (i % 12)));
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    frm.push_back(8'h45); frm.push_back(8'h00);
    frm.push_back(tlen[15:8]); frm.push_back(tlen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h11);
    frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'h0A); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h05);
    frm.push_back(dip[31:24]); frm.push_back(dip[23:16]); frm.push_back(dip[15:8]); frm.push_back(dip[7:0]);
    frm.push_back(8'h30); frm.push_back(8'h39);
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int unsigned i = 0; i < plen; i++) frm.push_back(8'(i + seed));
    while (frm.size() < padto) frm.push_back(8'h00);
    sum = 0;
    for (int unsigned i = 14; i < 34; i += 2) sum += {16'd0, frm[i], frm[i+1]};
    sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = (sum & 32'hFFFF) + (sum >> 16);
    frm[24] = ~sum[15:8];
    frm[25] = ~sum[7:0];
  endtask

  task automatic send_frame(input int unsigned max_w);
    int unsigned nw, nb, guard;
    logic [31:0] d;
    logic        took;
    nw = (frm.size() + 3) / 4;
    for (int unsigned w = 0; w < nw && w < max_w; w++) begin
      nb = (frm.size() - w*4 >= 4) ? 4 : frm.size() - w*4;
      d = '0;
      for (int unsigned b = 0; b < nb; b++) d = {d[23:0], frm[w*4+b]};
      axis_tdata_in  = d;
      axis_tkeep_in  = 4'((1 << nb) - 1);
      axis_tlast_in  = (w == nw - 1);
      axis_tvalid_in = 1'b1;
      took  = 1'b0;
      guard = 0;
      while (!took && guard < 2000) begin
        @(negedge clk_32);
        took = axis_tready_out;
        if (!took) stalls++;
        @(posedge clk_32);
        #1;
        guard++;
      end
      if (!took) begin
        chk("send accept", took, 1);
        break;
      end
    end
    axis_tvalid_in = 1'b0;
    axis_tlast_in  = 1'b0;
    axis_tkeep_in  = '0;
  endtask

  task automatic drain();
    repeat (40) @(posedge clk_32);
    #1;
  endtask

  function automatic logic [31:0] ob_d(input int unsigned i);
    return (i < ob_data.size()) ? ob_data[i] : 32'hDEADDEAD;
  endfunction

  task automatic expect_payload(input string tag, input int unsigned base,
                                input int unsigned plen, input int unsigned seed);
    int unsigned nbeats, nb, idx;
    logic [31:0] ed;
    logic [3:0]  ek;
    nbeats = (plen + 3) / 4;
    chk({tag, " beats"}, ob_data.size() - base, nbeats);
    for (int unsigned k = 0; k < nbeats && base + k < ob_data.size(); k++) begin
      ed = '0;
      for (int unsigned b = 0; b < 4; b++) begin
        idx = 4*k + b;
        ed  = {ed[23:0], (idx < plen) ? 8'(idx + seed) : 8'h00};
      end
      nb = (plen - 4*k >= 4) ? 4 : plen - 4*k;
      ek = 4'(4'hF << (4 - nb));
      chk($sformatf("%s w%0d data", tag, k), ob_data[base+k], ed);
      chk($sformatf("%s w%0d keep/last", tag, k), {ob_keep[base+k], ob_last[base+k]},
          {ek, k == nbeats - 1});
    end
  endtask

  task automatic check_cnts(input string tag);
    chk({tag, " ok_cnt"}, frame_ok_cnt, exp_ok);
    chk({tag, " drop_cnt"}, frame_drop_cnt, exp_drop);
  endtask

  int unsigned base, m0, r0, s0, last_seen, exp_beats6;

  initial begin
    reset_32_n     = 1'b0;
    axis_tdata_in  = '0;
    axis_tkeep_in  = '0;
    axis_tvalid_in = 1'b0;
    axis_tlast_in  = 1'b0;
    repeat (3) @(negedge clk_32);
    chk("rst tvalid_out", axis_tvalid_out, 0);
    chk("rst tdata/keep/last", {axis_tdata_out, axis_tkeep_out, axis_tlast_out}, 0);
    chk("rst meta", {meta_valid, meta_len, meta_src_port}, 0);
    chk("rst meta_ip", meta_src_ip, 0);
    check_cnts("rst");
    @(posedge clk_32); #1;
    reset_32_n = 1'b1;
    repeat (2) @(posedge clk_32); #1;

    // 1: valid frame, 10-byte payload 00..09
    build(16'h0800, 32'hC0A80102, 16'h1F90, 10, 0, 0);
    base = ob_data.size(); m0 = meta_cnt;
    send_frame(1000); drain();
    exp_ok++;
    chk("t1 w0", ob_d(base), 32'h00010203);
    chk("t1 w1", ob_d(base+1), 32'h04050607);
    chk("t1 w2", ob_d(base+2), 32'h08090000);
    expect_payload("t1", base, 10, 0);
    chk("t1 meta pulses", meta_cnt - m0, 1);
    chk("t1 meta_len", meta_len, 10);
    chk("t1 meta_src_ip", meta_src_ip, 32'h0A000005);
    chk("t1 meta_src_port", meta_src_port, 16'h3039);
    check_cnts("t1");

    // 2: wrong destination port
    build(16'h0800, 32'hC0A80102, 16'h1F91, 10, 0, 0);
    base = ob_data.size(); m0 = meta_cnt; s0 = stalls;
    send_frame(1000); drain();
    exp_drop++;
    chk("t2 beats", ob_data.size() - base, 0);
    chk("t2 stalls", stalls - s0, 0);
    chk("t2 meta pulses", meta_cnt - m0, 0);
    chk("t2 meta_len held", meta_len, 10);
    check_cnts("t2");

    // wrong IP, wrong ethertype, runt, zero-length UDP
    build(16'h0800, 32'hC0A80103, 16'h1F90, 8, 0, 0);
    base = ob_data.size(); send_frame(1000); drain(); exp_drop++;
    chk("bad ip beats", ob_data.size() - base, 0);
    build(16'h86DD, 32'hC0A80102, 16'h1F90, 8, 0, 0);
    base = ob_data.size(); send_frame(1000); drain(); exp_drop++;
    chk("bad etype beats", ob_data.size() - base, 0);
    build(16'h0800, 32'hC0A80102, 16'h1F90, 8, 0, 0);
    while (frm.size() > 30) void'(frm.pop_back());
    base = ob_data.size(); m0 = meta_cnt; send_frame(1000); drain(); exp_drop++;
    chk("runt beats", ob_data.size() - base, 0);
    chk("runt meta pulses", meta_cnt - m0, 0);
    build(16'h0800, 32'hC0A80102, 16'h1F90, 0, 0, 0);
    base = ob_data.size(); send_frame(1000); drain(); exp_drop++;
    chk("ulen8 beats", ob_data.size() - base, 0);
    check_cnts("drops");

    // 3: 46-byte payload
    build(16'h0800, 32'hC0A80102, 16'h1F90, 46, 8'h30, 0);
    base = ob_data.size(); send_frame(1000); drain(); exp_ok++;
    expect_payload("t3", base, 46, 8'h30);
    chk("t3 meta_len", meta_len, 46);
    check_cnts("t3");

    // 3b: 6-byte payload with Ethernet padding to 60 bytes
    build(16'h0800, 32'hC0A80102, 16'h1F90, 6, 8'hA0, 60);
    base = ob_data.size(); send_frame(1000); drain(); exp_ok++;
    expect_payload("t3b", base, 6, 8'hA0);
    check_cnts("t3b");

    // 4: last input word keep 0111 -> flush word
    build(16'h0800, 32'hC0A80102, 16'h1F90, 9, 8'h40, 0);
    base = ob_data.size(); r0 = rdy_low; send_frame(1000); drain(); exp_ok++;
    expect_payload("t4", base, 9, 8'h40);
    chk("t4 tready low cycles", rdy_low - r0, 1);
    check_cnts("t4");

    // 5: 256-byte payload with random downstream backpressure
    build(16'h0800, 32'hC0A80102, 16'h1F90, 256, 8'h5A, 0);
    base = ob_data.size();
    rand_rdy = 1'b1;
    send_frame(1000); drain();
    rand_rdy = 1'b0;
    drain(); exp_ok++;
    expect_payload("t5", base, 256, 8'h5A);
    chk("t5 meta_len", meta_len, 256);
    check_cnts("t5");

    // 6: corrupted IP checksum, then a good frame
    build(16'h0800, 32'hC0A80102, 16'h1F90, 4, 8'h10, 0);
    frm[24] = frm[24] ^ 8'h01;
    base = ob_data.size(); send_frame(1000); drain();
`ifdef UDP_RX_IP_CSUM_EN
    exp_drop++;
    exp_beats6 = 0;
`else
    exp_ok++;
    exp_beats6 = 1;
`endif
    chk("t6 bad csum beats", ob_data.size() - base, exp_beats6);
    check_cnts("t6 bad");
    build(16'h0800, 32'hC0A80102, 16'h1F90, 5, 8'h20, 0);
    base = ob_data.size(); send_frame(1000); drain(); exp_ok++;
    expect_payload("t6 good", base, 5, 8'h20);
    check_cnts("t6 good");

    // reset in the middle of a frame
    build(16'h0800, 32'hC0A80102, 16'h1F90, 20, 0, 0);
    base = ob_data.size();
    send_frame(13);
    repeat (2) @(posedge clk_32); #1;
    reset_32_n = 1'b0;
    repeat (2) @(negedge clk_32);
    chk("midrst tvalid_out", axis_tvalid_out, 0);
    exp_ok = 0; exp_drop = 0;
    check_cnts("midrst");
    last_seen = 0;
    for (int unsigned i = base; i < ob_last.size(); i++) last_seen += ob_last[i];
    chk("midrst no tlast", last_seen, 0);
    @(posedge clk_32); #1;
    reset_32_n = 1'b1;
    repeat (2) @(posedge clk_32); #1;
    build(16'h0800, 32'hC0A80102, 16'h1F90, 7, 8'h77, 0);
    base = ob_data.size(); send_frame(1000); drain(); exp_ok++;
    expect_payload("postrst", base, 7, 8'h77);
    check_cnts("postrst");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
